serial_subtractor: RTL and testbench

- Multi-cycle, digit-serial two's-complement subtractor with ripple borrow. It computes a - b - bin.
- It is the inverse-direction companion to the combinational ripple-carry adder. It is used where area matters more than latency, for example accumulator decrement paths and compare-by-subtract units.
- Operands are accepted over a valid/ready input handshake. The result is returned over a valid/ready output handshake after WIDTH/DIGIT processing cycles.

---
 rtl/serial_subtractor.sv | 174 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Digit-serial two's-complement subtractor computing a - b - bin with a
// rippling borrow flop. Operands enter over a valid/ready handshake, are
// consumed DIGIT bits per cycle LSB-first, and the result is presented over
// a second valid/ready handshake.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   in_valid_i   operands present
//   in_ready_o   block can accept operands (registered, high only in IDLE)
//   a_i, b_i     minuend / subtrahend, WIDTH bits
//   bin_i        borrow-in
//   out_valid_o  result present
//   out_ready_i  consumer accepts result
//   diff_o       (a - b - bin) mod 2^WIDTH
//   bout_o       unsigned borrow-out (a < b + bin)
//   ovf_o        signed overflow of the subtraction
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = $clog2(NUM + 1);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_subtractor: WIDTH must be at least 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_digit_check
    $error("serial_subtractor: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             inReady_q, inReady_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             msbIn_q, msbIn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // One digit of subtraction; the extra MSB is the borrow out of the digit.
  logic [DIGIT:0]   digitSub;
  logic             topIn;
  logic [WIDTH-1:0] resShift;

  assign digitSub = {1'b0, aSh_q[DIGIT-1:0]} - {1'b0, bSh_q[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, borrow_q};

  // Borrow arriving at the top bit of the current digit. On the last digit
  // this is the borrow into bit WIDTH-1, needed to derive signed overflow.
  if (DIGIT == 1) begin : g_top_single
    assign topIn = borrow_q;
  end else begin : g_top_multi
    logic [DIGIT-1:0] lowSub;
    assign lowSub = {1'b0, aSh_q[DIGIT-2:0]} - {1'b0, bSh_q[DIGIT-2:0]}
                    - {{(DIGIT-1){1'b0}}, borrow_q};
    assign topIn = lowSub[DIGIT-1];
  end

  // New digit enters the result register from the MSB end.
  assign resShift = (res_q >> DIGIT) | (WIDTH'(digitSub[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Next-state and datapath control. The cycle after the last digit is the
  // DONE-entry cycle, which publishes the result registers.
  always_comb begin
    state_d    = state_q;
    aSh_d      = aSh_q;
    bSh_d      = bSh_q;
    res_d      = res_q;
    borrow_d   = borrow_q;
    msbIn_d    = msbIn_q;
    cnt_d      = cnt_q;
    outValid_d = outValid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && inReady_q) begin
          aSh_d    = a_i;
          bSh_d    = b_i;
          borrow_d = bin_i;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(NUM)) begin
          diff_d     = res_q;
          bout_d     = borrow_q;
          ovf_d      = msbIn_q ^ borrow_q;
          outValid_d = 1'b1;
          state_d    = DONE;
        end else begin
          res_d    = resShift;
          borrow_d = digitSub[DIGIT];
          aSh_d    = aSh_q >> DIGIT;
          bSh_d    = bSh_q >> DIGIT;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(NUM - 1)) begin
            msbIn_d = topIn;
          end
        end
      end
      DONE: begin
        if (outValid_q && out_ready_i) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // in_ready stays low through reset and rises on the first edge after it.
    inReady_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b0;
      aSh_q      <= '0;
      bSh_q      <= '0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      msbIn_q    <= 1'b0;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inReady_q  <= inReady_d;
      aSh_q      <= aSh_d;
      bSh_q      <= bSh_d;
      res_q      <= res_d;
      borrow_q   <= borrow_d;
      msbIn_q    <= msbIn_d;
      cnt_q      <= cnt_d;
      outValid_q <= outValid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign diff_o      = diff_q;
  assign bout_o      = bout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Exercises an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance
// of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       inValid8 = 0, outReady8 = 0, bin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       inReady8, outValid8, bout8, ovf8;
  logic [7:0] diff8;

  logic        inValid16 = 0, outReady16 = 0, bin16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        inReady16, outValid16, bout16, ovf16;
  logic [15:0] diff16;

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid_i(inValid8), .in_ready_o(inReady8),
    .a_i(a8), .b_i(b8), .bin_i(bin8),
    .out_valid_o(outValid8), .out_ready_i(outReady8),
    .diff_o(diff8), .bout_o(bout8), .ovf_o(ovf8)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid_i(inValid16), .in_ready_o(inReady16),
    .a_i(a16), .b_i(b16), .bin_i(bin16),
    .out_valid_o(outValid16), .out_ready_i(outReady16),
    .diff_o(diff16), .bout_o(bout16), .ovf_o(ovf16)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input longint a, input longint b,
                                input longint bin, output longint d,
                                output bit bo, output bit ov);
    longint full, sa, sb, sr, half;
    half = longint'(1) << (w - 1);
    full = a - b - bin;
    d    = full & ((longint'(1) << w) - 1);
    bo   = (full < 0);
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    sr   = sa - sb - bin;
    ov   = (sr < -half) || (sr > half - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cycleCnt++;
  endtask

  // Offers one operand set to the 8-bit instance, scrambles the inputs after
  // acceptance, and counts edges until out_valid (99 = never seen).
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output bit busyOk);
    int n = 0;
    while (!inReady8 && n < 20) begin step(); n++; end
    a8 = a; b8 = b; bin8 = bin; inValid8 = 1;
    step();
    inValid8 = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0;
    busyOk = 1;
    while (!outValid8 && lat < 40) begin
      step();
      lat++;
      if (inReady8 !== 1'b0) busyOk = 0;
    end
    if (!outValid8) lat = 99;
  endtask

  task automatic release8();
    outReady8 = 1;
    step();
    outReady8 = 0;
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output int lat, output int acceptCycle);
    int n = 0;
    while (!inReady16 && n < 20) begin step(); n++; end
    a16 = a; b16 = b; bin16 = bin; inValid16 = 1;
    step();
    acceptCycle = cycleCnt;
    inValid16 = 0;
    a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
    lat = 0;
    while (!outValid16 && lat < 40) begin step(); lat++; end
    if (!outValid16) lat = 99;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({inReady8, outValid8, diff8, bout8, ovf8} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset8 got rdy=%b vld=%b diff=%h bout=%b ovf=%b want all 0",
               inReady8, outValid8, diff8, bout8, ovf8);
    end
    total++;
    if ({inReady16, outValid16, diff16, bout16, ovf16} !== 20'h00000) begin
      bad++;
      $display("[TB] FAIL reset16 got rdy=%b vld=%b diff=%h want all 0",
               inReady16, outValid16, diff16);
    end
    step(); step();
    rst = 0;
    total++;
    if (inReady8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ready_before_edge got %b want 0", inReady8);
    end
    step();
    total++;
    if (inReady8 !== 1'b1 || inReady16 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_release got %b/%b want 1/1", inReady8, inReady16);
    end
  endtask

  task automatic test_basic();
    logic [7:0] ta[4] = '{8'h5A, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tb[4] = '{8'h23, 8'h01, 8'h01, 8'hFF};
    int lat;
    bit busyOk, bo, ov;
    longint d;
    for (int i = 0; i < 4; i++) begin
      drive8(ta[i], tb[i], 1'b0, lat, busyOk);
      model(8, longint'(ta[i]), longint'(tb[i]), 0, d, bo, ov);
      total++;
      if (lat !== 9 || !busyOk) begin
        bad++;
        $display("[TB] FAIL latency8 case %0d got lat=%0d busyOk=%b want 9/1", i, lat, busyOk);
      end
      total++;
      if (diff8 !== 8'(d) || bout8 !== bo || ovf8 !== ov) begin
        bad++;
        $display("[TB] FAIL result8 case %0d got %h/%b/%b want %h/%b/%b",
                 i, diff8, bout8, ovf8, 8'(d), bo, ov);
      end
      release8();
      total++;
      if (outValid8 !== 1'b0 || inReady8 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL handshake8 case %0d got vld=%b rdy=%b want 0/1", i, outValid8, inReady8);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    bit busyOk;
    drive8(8'h10, 8'h10, 1'b1, lat, busyOk);
    total++;
    if (diff8 !== 8'hFF || bout8 !== 1'b1 || ovf8 !== 1'b0 || lat !== 9) begin
      bad++;
      $display("[TB] FAIL equal_bin got %h/%b/%b lat=%0d want ff/1/0 lat=9", diff8, bout8, ovf8, lat);
    end
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); inValid8 = ~inValid8;
      step();
      total++;
      if (diff8 !== 8'hFF || bout8 !== 1'b1 || ovf8 !== 1'b0 ||
          outValid8 !== 1'b1 || inReady8 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold cycle %0d got %h/%b/%b vld=%b rdy=%b want ff/1/0 1 0",
                 i, diff8, bout8, ovf8, outValid8, inReady8);
      end
    end
    inValid8 = 0;
    release8();
    total++;
    if (outValid8 !== 1'b0 || inReady8 !== 1'b1 || diff8 !== 8'hFF || bout8 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_release got vld=%b rdy=%b diff=%h bout=%b want 0/1/ff/1",
               outValid8, inReady8, diff8, bout8);
    end
    // Extra out_ready while idle must not create a result.
    outReady8 = 1;
    step();
    outReady8 = 0;
    total++;
    if (outValid8 !== 1'b0 || inReady8 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_out_ready got vld=%b rdy=%b want 0/1", outValid8, inReady8);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    bit busyOk;
    bit sawValid = 0;
    a8 = 8'hC3; b8 = 8'h3C; bin8 = 0; inValid8 = 1;
    step();
    inValid8 = 0;
    step(); step(); step();
    rst = 1;
    #1;
    total++;
    if ({outValid8, diff8, bout8, ovf8, inReady8} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL mid_reset got vld=%b diff=%h bout=%b ovf=%b rdy=%b want all 0",
               outValid8, diff8, bout8, ovf8, inReady8);
    end
    step(); step();
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (outValid8) sawValid = 1;
    end
    total++;
    if (sawValid) begin
      bad++;
      $display("[TB] FAIL no_partial_result got out_valid=1 want 0");
    end
    drive8(8'h03, 8'h05, 1'b0, lat, busyOk);
    total++;
    if (diff8 !== 8'hFE || bout8 !== 1'b1 || ovf8 !== 1'b0 || lat !== 9) begin
      bad++;
      $display("[TB] FAIL after_reset got %h/%b/%b lat=%0d want fe/1/0 lat=9", diff8, bout8, ovf8, lat);
    end
    release8();
  endtask

  task automatic test_random8();
    int lat;
    bit busyOk, bo, ov;
    longint d;
    logic [7:0] ra, rb;
    logic rbin;
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      drive8(ra, rb, rbin, lat, busyOk);
      model(8, longint'(ra), longint'(rb), longint'(rbin), d, bo, ov);
      total++;
      if (diff8 !== 8'(d) || bout8 !== bo || ovf8 !== ov || lat !== 9) begin
        bad++;
        $display("[TB] FAIL random8 %h-%h-%b got %h/%b/%b lat=%0d want %h/%b/%b lat=9",
                 ra, rb, rbin, diff8, bout8, ovf8, lat, 8'(d), bo, ov);
      end
      release8();
    end
  endtask

  task automatic test_digit4();
    int lat, acc;
    drive16(16'h1234, 16'h4321, 1'b1, lat, acc);
    total++;
    if (diff16 !== 16'hCF12 || bout16 !== 1'b1 || ovf16 !== 1'b0 || lat !== 5) begin
      bad++;
      $display("[TB] FAIL digit4 got %h/%b/%b lat=%0d want cf12/1/0 lat=5", diff16, bout16, ovf16, lat);
    end
    outReady16 = 1;
    step();
    outReady16 = 0;
    total++;
    if (outValid16 !== 1'b0 || inReady16 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL digit4_handshake got vld=%b rdy=%b want 0/1", outValid16, inReady16);
    end
  endtask

  task automatic test_back_to_back();
    int lat, acc, prevAcc;
    bit bo, ov;
    longint d;
    logic [15:0] ra, rb;
    logic rbin;
    prevAcc = 0;
    outReady16 = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 50 == 0) rb = ra;
      if (i % 77 == 0) begin ra = 16'h8000; rb = 16'($urandom_range(1, 16'hFFFF)); end
      drive16(ra, rb, rbin, lat, acc);
      model(16, longint'(ra), longint'(rb), longint'(rbin), d, bo, ov);
      total++;
      if (diff16 !== 16'(d) || bout16 !== bo || ovf16 !== ov || lat !== 5) begin
        bad++;
        $display("[TB] FAIL b2b %h-%h-%b got %h/%b/%b lat=%0d want %h/%b/%b lat=5",
                 ra, rb, rbin, diff16, bout16, ovf16, lat, 16'(d), bo, ov);
      end
      if (i > 0) begin
        total++;
        if (acc - prevAcc !== 7) begin
          bad++;
          $display("[TB] FAIL interval got %0d want 7", acc - prevAcc);
        end
      end
      prevAcc = acc;
    end
    step();
    outReady16 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_mid_reset();
    test_random8();
    test_digit4();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
